// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake and block-RAM data-port bundle for mem_access_unit.
// The master modport is the load/store unit's view; the slave modport is the execute stage and RAM side.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 31,
   parameter int DATA_WIDTH = 31
);
   logic                i_req_valid;
   logic                o_req_ready;
   logic                i_req_we;
   logic [2:0]          i_funct3;
   logic [31:0]         i_addr;
   logic [31:0]         i_wdata;
   logic                o_rsp_valid;
   logic                o_rsp_err;
   logic [31:0]         o_rdata;
   logic                o_read_req;
   logic [ADDR_WIDTH:0] o_read_addr;
   logic [DATA_WIDTH:0] i_read_data;
   logic                o_write_enable;
   logic [3:0]          o_byte_enable;
   logic [ADDR_WIDTH:0] o_write_addr;
   logic [DATA_WIDTH:0] o_write_data;

   modport master (
      input  i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_read_data,
      output o_req_ready, o_rsp_valid, o_rsp_err, o_rdata,
      output o_read_req, o_read_addr, o_write_enable, o_byte_enable, o_write_addr, o_write_data
   );

   modport slave (
      output i_req_valid, i_req_we, i_funct3, i_addr, i_wdata, i_read_data,
      input  o_req_ready, o_rsp_valid, o_rsp_err, o_rdata,
      input  o_read_req, o_read_addr, o_write_enable, o_byte_enable, o_write_addr, o_write_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator driving a block RAM with a one-cycle registered read.
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word accesses are reported as
// errors; when undefined, the byte offset is truncated to natural alignment and the access proceeds.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 31,
   parameter int DATA_WIDTH = 31
) (
   input  logic clk,
   input  logic rst,
   input  logic clk_en,
   mem_access_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [ADDR_WIDTH:0] addr_q;
   logic [1:0]          off_q;
   logic [2:0]          funct3_q;
   logic                we_q;
   logic                err_q;
   logic [3:0]          be_q;
   logic [DATA_WIDTH:0] wdata_q;
   logic [DATA_WIDTH:0] rdata_q;

   logic [33:0]         addr_ext;
   logic [1:0]          off_raw;
   logic [1:0]          off_eff;
   logic                illegal;
   logic                misaligned;
   logic                req_err;
   logic [3:0]          be_next;
   logic [DATA_WIDTH:0] wdata_next;
   logic                accept;
   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] load_val;

   // Zero-extend the byte address so the word-address slice stays in range for any ADDR_WIDTH <= 31.
   assign addr_ext = {2'b00, bus.i_addr};
   assign off_raw  = addr_ext[1:0];

   // Classify the incoming request: illegal funct3, misalignment, and the offset actually used.
   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      off_eff    = off_raw;
      if (bus.i_req_we) begin
         illegal = (bus.i_funct3 > 3'd2);
      end else begin
         illegal = (bus.i_funct3 == 3'd3) || (bus.i_funct3 == 3'd6) || (bus.i_funct3 == 3'd7);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      case (bus.i_funct3[1:0])
         2'd1:    misaligned = off_raw[0];
         2'd2:    misaligned = (off_raw != 2'd0);
         default: misaligned = 1'b0;
      endcase
`else
      case (bus.i_funct3[1:0])
         2'd1:    off_eff = {off_raw[1], 1'b0};
         2'd2:    off_eff = 2'd0;
         default: off_eff = off_raw;
      endcase
`endif
      req_err = illegal | misaligned;
   end

   // Steer store data onto the byte lanes: narrow stores are replicated so any lane sees the value.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = bus.i_wdata;
      case (bus.i_funct3[1:0])
         2'd0: begin
            be_next    = 4'b0001 << off_eff;
            wdata_next = {4{bus.i_wdata[7:0]}};
         end
         2'd1: begin
            be_next    = 4'b0011 << off_eff;
            wdata_next = {2{bus.i_wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = bus.i_wdata;
         end
      endcase
   end

   // Align the returned RAM word to the addressed byte and extend it according to the load type.
   always_comb begin
      shifted = bus.i_read_data >> {off_q, 3'b000};
      case (funct3_q)
         3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'd4:    load_val = {24'd0, shifted[7:0]};
         3'd5:    load_val = {16'd0, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   // Next-state logic; every transition waits for clk_en so a stalled pipeline freezes the unit.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (clk_en && bus.i_req_valid) begin
               accept     = 1'b1;
               state_next = req_err ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (clk_en) state_next = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (clk_en) state_next = RESP;
         end
         RESP: begin
            if (clk_en) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Decode handshake and RAM strobes from the state so a reset drops them without waiting for an edge.
   always_comb begin
      bus.o_req_ready    = (state == IDLE);
      bus.o_rsp_valid    = (state == RESP);
      bus.o_rsp_err      = (state == RESP) && err_q;
      bus.o_read_req     = (state == ISSUE) && !we_q;
      bus.o_write_enable = (state == ISSUE) && we_q;
      bus.o_read_addr    = addr_q;
      bus.o_write_addr   = addr_q;
      bus.o_byte_enable  = be_q;
      bus.o_write_data   = wdata_q;
      bus.o_rdata        = rdata_q;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the accepted request, hold the RAM-facing buses, and register the load result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         off_q    <= 2'd0;
         funct3_q <= 3'd0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         be_q     <= 4'd0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else if (clk_en) begin
         if (accept) begin
            off_q    <= off_eff;
            funct3_q <= bus.i_funct3;
            we_q     <= bus.i_req_we;
            err_q    <= req_err;
            if (req_err) begin
               rdata_q <= '0;
            end else begin
               addr_q <= addr_ext[ADDR_WIDTH+2:2];
               if (bus.i_req_we) begin
                  be_q    <= be_next;
                  wdata_q <= wdata_next;
               end
            end
         end
         if (state == ISSUE && we_q) begin
            rdata_q <= '0;
         end
         if (state == WAIT) begin
            rdata_q <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a one-cycle registered RAM model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_unit;

   logic clk;
   logic rst;
   logic clk_en;

   mem_access_unit_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) ifc ();

   mem_access_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .bus    (ifc)
   );

   typedef struct {
      logic        err;
      logic        we;
      logic [31:0] rdata;
      int          acc_cycle;
      int          lat;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } strb_t;

   rsp_t        rsp_q[$];
   strb_t       strb_q[$];
   int          assert_count = 0;
   int          fail_count = 0;
   int          ecount = 0;
   int          rsp_seen = 0;
   int          write_count = 0;
   logic [31:0] rd_word = 32'd0;
   logic [31:0] last_rdata = 32'd0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count enabled edges so latencies are measured in advancing cycles.
   always @(posedge clk) begin
      if (clk_en) ecount <= ecount + 1;
   end

   // RAM model: registered read one enabled edge after the request, and a write counter.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifc.i_read_data <= 32'd0;
      end else if (clk_en) begin
         if (ifc.o_read_req) ifc.i_read_data <= rd_word;
         if (ifc.o_write_enable) write_count <= write_count + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      if (we) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((f3 == 3'd1 || f3 == 3'd5) && off[0]) bad = 1'b1;
      if (f3 == 3'd2 && off != 2'd0) bad = 1'b1;
`else
      if (off == 2'd3 && f3 == 3'd7) bad = 1'b1;
`endif
      return bad;
   endfunction

   function automatic logic [1:0] model_off(input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3 == 3'd7) return off;
      return off;
`else
      if (f3 == 3'd1 || f3 == 3'd5) return {off[1], 1'b0};
      if (f3 == 3'd2) return 2'd0;
      return off;
`endif
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return w;
      endcase
   endfunction

   // Drive one request, wait (bounded) for acceptance, and push the expected strobe and response.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rword);
      int    waited = 0;
      bit    accepted = 0;
      rsp_t  r;
      strb_t s;
      logic  err;
      logic [1:0] off;
      rd_word         = rword;
      ifc.i_req_valid = 1'b1;
      ifc.i_req_we    = we;
      ifc.i_funct3    = f3;
      ifc.i_addr      = addr;
      ifc.i_wdata     = wdata;
      while (!accepted && waited < 50) begin
         @(negedge clk);
         accepted = ifc.o_req_ready && clk_en;
         @(posedge clk);
         waited++;
      end
      #1;
      ifc.i_req_valid = 1'b0;
      if (!accepted) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
      end else begin
         off         = model_off(f3, addr[1:0]);
         err         = model_err(we, f3, addr[1:0]);
         r.err       = err;
         r.we        = we;
         r.rdata     = err ? 32'd0 : model_load(f3, off, rword);
         r.acc_cycle = ecount;
         r.lat       = err ? 0 : (we ? 1 : 2);
         rsp_q.push_back(r);
         if (!err) begin
            s.we    = we;
            s.addr  = {2'b00, addr[31:2]};
            s.wdata = wdata;
            s.be    = 4'b1111;
            if (f3 == 3'd0) begin
               s.be    = 4'b0001 << off;
               s.wdata = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
            end else if (f3 == 3'd1) begin
               s.be    = 4'b0011 << off;
               s.wdata = {wdata[15:0], wdata[15:0]};
            end
            strb_q.push_back(s);
         end
      end
   endtask

   task automatic drainResponses();
      int n = 0;
      while ((rsp_q.size() != 0 || strb_q.size() != 0) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (rsp_q.size() != 0 || strb_q.size() != 0) begin
         checkOutput("drain_timeout", 32'(rsp_q.size() + strb_q.size()), 32'd0);
         rsp_q.delete();
         strb_q.delete();
      end
   endtask

   // Response monitor: pop the scoreboard once per enabled response cycle.
   always @(negedge clk) begin
      rsp_t exp_r;
      if (rst && clk_en && ifc.o_rsp_valid) begin
         rsp_seen++;
         if (rsp_q.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_r = rsp_q.pop_front();
            checkOutput("rsp_err", 32'(ifc.o_rsp_err), 32'(exp_r.err));
            if (!exp_r.we || exp_r.err) checkOutput("rsp_rdata", ifc.o_rdata, exp_r.rdata);
            checkOutput("rsp_latency", 32'(ecount - exp_r.acc_cycle), 32'(exp_r.lat));
            last_rdata = ifc.o_rdata;
         end
      end
   end

   // Strobe monitor: every RAM access must match the next expected access.
   always @(negedge clk) begin
      strb_t exp_s;
      if (rst && clk_en && (ifc.o_read_req || ifc.o_write_enable)) begin
         if (strb_q.size() == 0) begin
            checkOutput("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            exp_s = strb_q.pop_front();
            checkOutput("strobe_we", 32'(ifc.o_write_enable), 32'(exp_s.we));
            checkOutput("strobe_rd", 32'(ifc.o_read_req), 32'(!exp_s.we));
            checkOutput("read_addr", ifc.o_read_addr, exp_s.addr);
            checkOutput("write_addr", ifc.o_write_addr, exp_s.addr);
            if (exp_s.we) begin
               checkOutput("byte_enable", 32'(ifc.o_byte_enable), 32'(exp_s.be));
               checkOutput("write_data", ifc.o_write_data, exp_s.wdata);
            end
         end
      end
   end

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed running expected finished");
      $fatal(1, "[TB] simulation timeout");
   end

   // Directed scenarios followed by a short randomized sweep.
   initial begin
      int          wc;
      int          rs;
      logic [31:0] snap;
      rst             = 1'b0;
      clk_en          = 1'b1;
      ifc.i_req_valid = 1'b0;
      ifc.i_req_we    = 1'b0;
      ifc.i_funct3    = 3'd0;
      ifc.i_addr      = 32'd0;
      ifc.i_wdata     = 32'd0;
      #3;
      checkOutput("rst_ready", 32'(ifc.o_req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(ifc.o_rsp_valid), 32'd0);
      checkOutput("rst_rsp_err", 32'(ifc.o_rsp_err), 32'd0);
      checkOutput("rst_rdata", ifc.o_rdata, 32'd0);
      checkOutput("rst_read_req", 32'(ifc.o_read_req), 32'd0);
      checkOutput("rst_write_en", 32'(ifc.o_write_enable), 32'd0);
      checkOutput("rst_byte_en", 32'(ifc.o_byte_enable), 32'd0);
      checkOutput("rst_read_addr", ifc.o_read_addr, 32'd0);
      checkOutput("rst_write_addr", ifc.o_write_addr, 32'd0);
      checkOutput("rst_write_data", ifc.o_write_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] SW 0x200");
      applyStimulus(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 32'd0);
      checkOutput("sw_write_addr", ifc.o_write_addr, 32'd128);
      checkOutput("sw_read_addr", ifc.o_read_addr, 32'd128);
      checkOutput("sw_byte_en", 32'(ifc.o_byte_enable), 32'hF);
      @(posedge clk);
      #1;
      checkOutput("sw_rsp_valid", 32'(ifc.o_rsp_valid), 32'd1);
      checkOutput("sw_rsp_err", 32'(ifc.o_rsp_err), 32'd0);
      drainResponses();

      $display("[TB] SB 0x203 then LB 0x203");
      applyStimulus(1'b1, 3'd0, 32'h203, 32'h41, 32'd0);
      checkOutput("sb_byte_en", 32'(ifc.o_byte_enable), 32'h8);
      checkOutput("sb_write_data", ifc.o_write_data, 32'h41414141);
      drainResponses();
      applyStimulus(1'b0, 3'd0, 32'h203, 32'd0, 32'h80000000);
      drainResponses();
      checkOutput("lb_rdata", last_rdata, 32'hFFFFFF80);

      $display("[TB] LHU 0x6");
      applyStimulus(1'b0, 3'd5, 32'h6, 32'd0, 32'hABCD1234);
      drainResponses();
      checkOutput("lhu_rdata", last_rdata, 32'h0000ABCD);

      $display("[TB] LW 0x5");
      applyStimulus(1'b0, 3'd2, 32'h5, 32'd0, 32'h5555AAAA);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("lw_mis_valid", 32'(ifc.o_rsp_valid), 32'd1);
      checkOutput("lw_mis_err", 32'(ifc.o_rsp_err), 32'd1);
      checkOutput("lw_mis_read_req", 32'(ifc.o_read_req), 32'd0);
      drainResponses();
      checkOutput("lw_mis_rdata", last_rdata, 32'd0);
`else
      checkOutput("lw_trunc_read_req", 32'(ifc.o_read_req), 32'd1);
      checkOutput("lw_trunc_read_addr", ifc.o_read_addr, 32'd1);
      drainResponses();
      checkOutput("lw_trunc_rdata", last_rdata, 32'h5555AAAA);
`endif

      $display("[TB] store funct3=3");
      applyStimulus(1'b1, 3'd3, 32'h100, 32'h12345678, 32'd0);
      checkOutput("bad_store_err", 32'(ifc.o_rsp_err), 32'd1);
      checkOutput("bad_store_we", 32'(ifc.o_write_enable), 32'd0);
      drainResponses();

      $display("[TB] clk_en stall in WAIT");
      applyStimulus(1'b0, 3'd2, 32'h40, 32'd0, 32'h12345678);
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      snap   = ifc.o_rdata;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("stall_rsp_valid", 32'(ifc.o_rsp_valid), 32'd0);
         checkOutput("stall_rdata", ifc.o_rdata, snap);
      end
      clk_en = 1'b1;
      drainResponses();
      checkOutput("stall_final_rdata", last_rdata, 32'h12345678);

      $display("[TB] random sweep");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       $urandom & 32'h0000_0FFF, $urandom, $urandom);
         drainResponses();
      end

      $display("[TB] reset during store ISSUE");
      applyStimulus(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'd0);
      checkOutput("abort_we_before", 32'(ifc.o_write_enable), 32'd1);
      wc = write_count;
      rs = rsp_seen;
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abort_we_after", 32'(ifc.o_write_enable), 32'd0);
      checkOutput("abort_ready", 32'(ifc.o_req_ready), 32'd1);
      rsp_q.delete();
      strb_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abort_no_write", 32'(write_count), 32'(wc));
      checkOutput("abort_no_rsp", 32'(rsp_seen), 32'(rs));

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
